pipe_ctrl: RTL

Central pipeline control for the 5-stage MIPS core; the producer of the stall[5:0] and flush vectors that every pipeline latch (pc, if_id, id_ex, ex_mem, mem_wb) consumes.
- Arbitrates per-stage stall requests into a stall vector.
- Turns MEM-stage exception types into a flush pulse plus redirect PC.
- Tracks stall activity with a performance counter and a stall watchdog.

---
 rtl/pipe_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Central pipeline control: arbitrates stage stall requests, converts MEM-stage
// exceptions into a flush pulse with redirect PC, and tracks stall activity.
module pipe_ctrl #(
   parameter int unsigned WDOG_LIMIT = 1024,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_if,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles,
   output logic        wdog_timeout
);

   localparam logic [31:0] EXC_ERET = 32'h0000_000e;
   localparam int CNT_W = $clog2(WDOG_LIMIT);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t            state, state_nxt;
   logic              exc;
   logic [5:0]        stall_req;
   logic [CNT_W-1:0]  wdog_cnt;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Outputs are gated by rst so they drop the moment reset is asserted.
   always_comb begin
      stall_req = 6'b000000;
      if (stallreq_from_mem)
         stall_req = 6'b011111;
      else if (stallreq_from_ex)
         stall_req = 6'b001111;
      else if (stallreq_from_id || stallreq_from_if)
         stall_req = 6'b000111;

      exc       = !rst && (state == RUN) && (excepttype_i != 32'd0);
      flush     = exc;
      stall     = 6'b000000;
      new_pc    = 32'd0;
      state_nxt = RUN;

      if (exc) begin
         state_nxt = DRAIN;
         new_pc    = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
      end else if (!rst) begin
         stall = stall_req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= 32'd0;
         wdog_cnt     <= '0;
         wdog_timeout <= 1'b0;
      end else begin
         if (stall[0])
            stall_cycles <= sat_inc(stall_cycles);

         wdog_timeout <= 1'b0;
         if ((stall == 6'b000000) || flush) begin
            wdog_cnt <= '0;
         end else if (wdog_cnt == WDOG_LAST) begin
            wdog_cnt     <= '0;
            wdog_timeout <= 1'b1;
         end else begin
            wdog_cnt <= wdog_cnt + CNT_W'(1);
         end
      end
   end

endmodule
